// File: rtl/seq_signed_divider.sv
// seq_signed_divider: iterative radix-2 restoring signed divider.
// Divides a 2*WIDTH-bit signed dividend by a WIDTH-bit signed divisor and
// produces one quotient bit per clock on operand magnitudes. The signs are
// applied afterwards.
// Optional macro SEQ_DIVIDER_EARLY_EXIT_EN: when |dividend| < |divisor|, the
// divider skips the iteration and returns quotient 0 with the dividend as
// the remainder.
module seq_signed_divider #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2*WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     quotient,
  output logic [WIDTH-1:0]     remainder,
  output logic                 div_by_zero,
  output logic                 overflow
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_part;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_dvsr;
  logic               r_sign_q;
  logic               r_sign_r;
  logic [CW-1:0]      r_count;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_quotient;
  logic [WIDTH-1:0]   r_remainder;
  logic               r_dbz;
  logic               r_ovf;

  logic [2*WIDTH-1:0] w_dividend_mag;
  logic [WIDTH-1:0]   w_divisor_mag;
  logic               w_accept;
  logic               w_hi_ovf;
  logic [WIDTH:0]     w_shift;
  logic               w_ge;
  logic [WIDTH-1:0]   w_diff;
  logic [WIDTH-1:0]   w_q_signed;
  logic [WIDTH-1:0]   w_r_signed;
  logic               w_q_ovf;
`ifdef SEQ_DIVIDER_EARLY_EXIT_EN
  logic               w_small;
`endif

  // in_ready follows rst combinationally so it is low for the whole reset
  assign in_ready = (r_state == IDLE) && !rst;
  assign w_accept = in_valid && in_ready;

  // Operand magnitudes. The most negative divisor maps onto 2^(WIDTH-1),
  // which still fits in WIDTH unsigned bits.
  assign w_dividend_mag = dividend[2*WIDTH-1] ? -dividend : dividend;
  assign w_divisor_mag  = divisor[WIDTH-1]    ? -divisor  : divisor;

  // If the upper half is already >= divisor, the quotient needs more than WIDTH bits
  assign w_hi_ovf = (w_dividend_mag[2*WIDTH-1:WIDTH] >= w_divisor_mag);
`ifdef SEQ_DIVIDER_EARLY_EXIT_EN
  assign w_small  = (w_dividend_mag < {{WIDTH{1'b0}}, w_divisor_mag});
`endif

  // One restoring step: shift in the next dividend bit, then trial-subtract.
  // The partial remainder stays below the divisor, so the difference fits
  // in WIDTH bits.
  assign w_shift = {r_part, r_quo[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, r_dvsr});
  assign w_diff  = w_shift[WIDTH-1:0] - r_dvsr;

  // Apply the signs and check the representable range of the signed quotient
  assign w_q_signed = r_sign_q ? -r_quo  : r_quo;
  assign w_r_signed = r_sign_r ? -r_part : r_part;
  assign w_q_ovf    = r_sign_q ? (r_quo[WIDTH-1] && (|r_quo[WIDTH-2:0]))
                               : r_quo[WIDTH-1];

  assign out_valid   = r_out_valid;
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;
  assign overflow    = r_ovf;

  // Control FSM and datapath: accept with pre-checks, iterate, sign-fix, hold result
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_part      <= '0;
      r_quo       <= '0;
      r_dvsr      <= '0;
      r_sign_q    <= 1'b0;
      r_sign_r    <= 1'b0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_sign_q <= dividend[2*WIDTH-1] ^ divisor[WIDTH-1];
            r_sign_r <= dividend[2*WIDTH-1];
            r_dvsr   <= w_divisor_mag;
            r_part   <= w_dividend_mag[2*WIDTH-1:WIDTH];
            r_quo    <= w_dividend_mag[WIDTH-1:0];
            r_count  <= '0;
            if (divisor == '0) begin
              r_state     <= DONE;
              r_out_valid <= 1'b1;
              r_quotient  <= '1;
              r_remainder <= dividend[WIDTH-1:0];
              r_dbz       <= 1'b1;
              r_ovf       <= 1'b0;
            end
`ifdef SEQ_DIVIDER_EARLY_EXIT_EN
            else if (w_small) begin
              r_state     <= DONE;
              r_out_valid <= 1'b1;
              r_quotient  <= '0;
              r_remainder <= dividend[WIDTH-1:0];
              r_dbz       <= 1'b0;
              r_ovf       <= 1'b0;
            end
`endif
            else if (w_hi_ovf) begin
              r_state     <= DONE;
              r_out_valid <= 1'b1;
              r_quotient  <= '0;
              r_remainder <= '0;
              r_dbz       <= 1'b0;
              r_ovf       <= 1'b1;
            end else begin
              r_state <= CALC;
            end
          end
        end
        CALC: begin
          r_part  <= w_ge ? w_diff : w_shift[WIDTH-1:0];
          r_quo   <= {r_quo[WIDTH-2:0], w_ge};
          r_count <= r_count + CW'(1);
          if (r_count == LAST_STEP) begin
            r_state <= SIGN;
          end
        end
        SIGN: begin
          r_state     <= DONE;
          r_out_valid <= 1'b1;
          r_dbz       <= 1'b0;
          if (w_q_ovf) begin
            r_quotient  <= '0;
            r_remainder <= '0;
            r_ovf       <= 1'b1;
          end else begin
            r_quotient  <= w_q_signed;
            r_remainder <= w_r_signed;
            r_ovf       <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_signed_divider.sv
// tb_seq_signed_divider: table-driven directed vectors, hand-written
// reset and backpressure sequences, and randomized operands checked
// against a plain-arithmetic reference model.
module tb_seq_signed_divider;

  localparam int NORM_LAT = 34;
`ifdef SEQ_DIVIDER_EARLY_EXIT_EN
  localparam int SMALL_LAT = 1;
`else
  localparam int SMALL_LAT = NORM_LAT;
`endif

  typedef struct {
    logic [63:0] dd;
    logic [31:0] dv;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    logic        ovf;
    int          lat;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] dividend;
  logic [31:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  seq_signed_divider #(.WIDTH(32)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .dividend(dividend),
    .divisor(divisor),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero),
    .overflow(overflow)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expectEq(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: Verilog-style signed division on 64-bit values, with the
  // error cases decided from the size of the true quotient
  function automatic vec_t refModel(input logic [63:0] dd, input logic [31:0] dv);
    vec_t        v;
    longint      sdd;
    longint      ldv;
    longint      lq;
    longint      lr;
    logic [63:0] udd;
    logic [63:0] udv;
    logic [63:0] magq;
    sdd = signed'(dd);
    ldv = signed'(dv);
    v.dd = dd; v.dv = dv;
    v.q = '0; v.r = '0; v.dbz = 1'b0; v.ovf = 1'b0; v.lat = NORM_LAT;
    if (ldv == 0) begin
      v.q = 32'hFFFF_FFFF;
      v.r = dd[31:0];
      v.dbz = 1'b1;
      v.lat = 1;
    end else begin
      udd = (sdd < 0) ? -dd : dd;
      udv = (ldv < 0) ? 64'(-ldv) : 64'(ldv);
      magq = udd / udv;
      if (magq > 64'h0000_0000_FFFF_FFFF) begin
        v.ovf = 1'b1;
        v.lat = 1;
      end else begin
        if (udd < udv) v.lat = SMALL_LAT;
        lq = sdd / ldv;
        lr = sdd % ldv;
        if (lq > 64'sd2147483647 || lq < -64'sd2147483648) begin
          v.ovf = 1'b1;
        end else begin
          v.q = 32'(lq);
          v.r = 32'(lr);
        end
      end
    end
    return v;
  endfunction

  // Present operands and wait (bounded) for the accepting edge
  task automatic applyStimulus(input logic [63:0] dd, input logic [31:0] dv);
    int guard;
    dividend = dd;
    divisor  = dv;
    in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) begin
      expectEq("accept_timeout", 64'(in_ready), 64'd1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input vec_t v, input int lat, input bit leak);
    expectEq({tag, ".latency"},  64'(lat), 64'(v.lat));
    expectEq({tag, ".quotient"}, 64'(quotient), 64'(v.q));
    expectEq({tag, ".remainder"}, 64'(remainder), 64'(v.r));
    expectEq({tag, ".div_by_zero"}, 64'(div_by_zero), 64'(v.dbz));
    expectEq({tag, ".overflow"}, 64'(overflow), 64'(v.ovf));
    expectEq({tag, ".in_ready_busy"}, 64'(leak), 64'd0);
  endtask

  // Hold the result for readyDelay cycles, then complete the output handshake
  task automatic holdAndRelease(input string tag, input vec_t v, input int readyDelay);
    for (int i = 0; i < readyDelay; i++) begin
      @(posedge clk); #1;
      expectEq({tag, ".hold_valid"}, 64'(out_valid), 64'd1);
      expectEq({tag, ".hold_quotient"}, 64'(quotient), 64'(v.q));
      expectEq({tag, ".hold_remainder"}, 64'(remainder), 64'(v.r));
      expectEq({tag, ".hold_in_ready"}, 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    expectEq({tag, ".released_valid"}, 64'(out_valid), 64'd0);
    expectEq({tag, ".released_in_ready"}, 64'(in_ready), 64'd1);
  endtask

  task automatic runVector(input string tag, input vec_t v, input int readyDelay);
    int lat;
    bit leak;
    applyStimulus(v.dd, v.dv);
    lat = 1;
    leak = 1'b0;
    while (!out_valid && lat < 100) begin
      if (in_ready) leak = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    checkOutput(tag, v, lat, leak);
    holdAndRelease(tag, v, readyDelay);
  endtask

  // Random dividend shapes: 32-bit, product of two 32-bit values, full 64-bit, tiny
  function automatic logic [63:0] randDividend();
    logic [31:0] a;
    logic [31:0] b;
    longint      pa;
    longint      pb;
    a = $urandom;
    b = $urandom;
    case ($urandom_range(0, 3))
      0: return {{32{a[31]}}, a};
      1: begin
        pa = signed'(a);
        pb = signed'(b);
        return 64'(pa * pb);
      end
      2: return {a, b};
      default: return 64'(longint'($urandom_range(0, 200)) - 64'sd100);
    endcase
  endfunction

  function automatic logic [31:0] randDivisor();
    logic [31:0] a;
    a = $urandom;
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3, 4: return 32'(int'($urandom_range(1, 20)) * (a[0] ? -1 : 1));
      default: return a;
    endcase
  endfunction

  vec_t table_v[13];

  initial begin
    vec_t v;
    bit   stray;

    table_v[0]  = '{64'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, NORM_LAT};
    table_v[1]  = '{-64'sd100, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 1'b0, NORM_LAT};
    table_v[2]  = '{-64'sd370370367, 32'd123456789, 32'hFFFF_FFFD, 32'd0, 1'b0, 1'b0, NORM_LAT};
    table_v[3]  = '{64'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1'b0, 1};
    table_v[4]  = '{64'h0000_0001_0000_0000, 32'd1, 32'd0, 32'd0, 1'b0, 1'b1, 1};
    table_v[5]  = '{-64'sd2147483648, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0, 1'b1, NORM_LAT};
    table_v[6]  = '{64'd2147483648, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 1'b0, NORM_LAT};
    table_v[7]  = '{64'd3, 32'd7, 32'd0, 32'd3, 1'b0, 1'b0, SMALL_LAT};
    table_v[8]  = '{-64'sd3, 32'd7, 32'd0, 32'hFFFF_FFFD, 1'b0, 1'b0, SMALL_LAT};
    table_v[9]  = '{64'd0, -32'sd5, 32'd0, 32'd0, 1'b0, 1'b0, SMALL_LAT};
    table_v[10] = '{-64'sd5, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 1'b0, 1};
    table_v[11] = '{64'h0000_0000_FFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b0, 1'b0, NORM_LAT};
    table_v[12] = '{64'h3FFF_FFFF_8000_0000, 32'h8000_0000, 32'h8000_0001, 32'd0, 1'b0, 1'b0, NORM_LAT};

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    dividend = '0;
    divisor = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    expectEq("reset.in_ready", 64'(in_ready), 64'd0);
    expectEq("reset.out_valid", 64'(out_valid), 64'd0);
    expectEq("reset.quotient", 64'(quotient), 64'd0);
    expectEq("reset.remainder", 64'(remainder), 64'd0);
    expectEq("reset.flags", 64'({div_by_zero, overflow}), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    expectEq("reset.in_ready_after", 64'(in_ready), 64'd1);

    // Directed vector table
    for (int i = 0; i < 13; i++) begin
      runVector($sformatf("vec%0d", i), table_v[i], 0);
    end

    // Flags persist in IDLE after a divide-by-zero result is consumed
    runVector("dbz_hold", table_v[3], 0);
    expectEq("dbz_hold.idle_flag", 64'(div_by_zero), 64'd1);
    expectEq("dbz_hold.idle_quotient", 64'(quotient), 64'hFFFF_FFFF);

    // Backpressure for 10 cycles, then back-to-back accept
    runVector("backpressure", table_v[0], 10);
    runVector("back_to_back", table_v[1], 0);

    // Reset in the middle of CALC, at count 10
    applyStimulus(64'd100, 32'd7);
    repeat (10) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    expectEq("midreset.out_valid", 64'(out_valid), 64'd0);
    expectEq("midreset.in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    expectEq("midreset.in_ready_after", 64'(in_ready), 64'd1);
    stray = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) stray = 1'b1;
    end
    expectEq("midreset.no_result", 64'(stray), 64'd0);
    runVector("midreset.next", table_v[0], 0);
    runVector("midreset.small", table_v[7], 0);

    // Randomized operands against the reference model
    for (int n = 0; n < 60; n++) begin
      v = refModel(randDividend(), randDivisor());
      runVector($sformatf("rand%0d", n), v, $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_signed_divider.md
Name: seq_signed_divider

Overview:
- Iterative signed divider, the inverse of the tree multiplier: takes a 2*WIDTH-bit signed dividend (e.g. a multiplier product) and a WIDTH-bit signed divisor.
- Returns a WIDTH-bit quotient and a WIDTH-bit remainder.
- Radix-2 restoring algorithm on magnitudes, one quotient bit per clock.
- Valid/ready handshake on both the input side and the output side.
- Sits in the arithmetic datapath beside the multiplier.

Parameters:
- WIDTH, 32, divisor/quotient/remainder width; dividend is 2*WIDTH.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operands valid
- in_ready  output  1  divider can accept operands
- dividend  input  2*WIDTH  signed dividend
- divisor  input  WIDTH  signed divisor
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- quotient  output  WIDTH  signed quotient, truncated toward zero
- remainder  output  WIDTH  signed remainder, same sign as dividend (or zero)
- div_by_zero  output  1  divisor was zero
- overflow  output  1  true quotient not representable in WIDTH signed bits

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset values:
  - state IDLE
  - in_ready=0 while rst is high, then 1
  - out_valid=0
  - quotient=0, remainder=0, div_by_zero=0, overflow=0
- Reset mid-operation: abandon the computation, return to IDLE, produce no result.
- in_ready=1 only in IDLE. Operands are accepted on the edge where in_valid&in_ready; operands are registered at that edge.
- On accept:
  - Latch sign_q = dividend MSB ^ divisor MSB and sign_r = dividend MSB.
  - Latch magnitudes |dividend| (2*WIDTH bits) and |divisor| (WIDTH bits, unsigned; -2^(WIDTH-1) handled).
- Pre-checks at accept, in priority order:
  1. divisor==0 -> DONE next edge: div_by_zero=1, overflow=0, quotient=all ones, remainder=dividend[WIDTH-1:0].
  2. |dividend|[2W-1:W] >= |divisor| -> DONE next edge: overflow=1, quotient=0, remainder=0.
  3. Otherwise -> CALC with count=0.
- States: IDLE -> CALC -> SIGN -> DONE -> IDLE.
- CALC, one step per cycle:
  - Partial remainder P (WIDTH+1 bits) shifts left, taking the next dividend bit.
  - If P >= |divisor|: P -= |divisor| and the quotient bit is 1; else the bit is 0.
  - Exactly WIDTH cycles, count 0..WIDTH-1, then SIGN.
- SIGN:
  - Apply sign_q to the quotient magnitude and sign_r to the remainder.
  - Post-check: positive quotient magnitude > 2^(W-1)-1, or negative quotient magnitude > 2^(W-1), gives overflow=1 with quotient=0, remainder=0.
  - Next state DONE.
- DONE:
  - out_valid=1; outputs stable until the edge where out_valid&out_ready.
  - Then IDLE, out_valid=0. Flags hold their values until the next result is loaded.
- Latency, acceptance edge to first out_valid cycle:
  - Normal: WIDTH+2 edges (34 at default).
  - Pre-check exits: 1 edge.
- Back-to-back: a new accept is possible the cycle after DONE handshakes; in_ready is 0 throughout CALC/SIGN/DONE.
- Results equal Verilog signed `/` and `%` for all non-error cases.

Optional Feature:
- Macro: SEQ_DIVIDER_EARLY_EXIT_EN.
- Defined: additional pre-check (after div-by-zero) for |dividend| < |divisor|. It goes straight to DONE next edge with quotient=0, remainder=dividend[WIDTH-1:0], no flags; latency 1.
- Undefined: such operands take the full WIDTH+2 path with identical results.

Test Plan:
- dividend=100, divisor=7 -> quotient=14, remainder=2, flags 0, out_valid exactly 34 cycles after accept, in_ready=0 meanwhile.
- dividend=-100, divisor=7 -> quotient=-14 (0xFFFFFFF2), remainder=-2 (0xFFFFFFFE); dividend=-370370367 (i.e. -3*123456789), divisor=123456789 -> quotient=-3, remainder=0.
- Zero divisor: dividend=5, divisor=0 -> div_by_zero=1, quotient=0xFFFFFFFF, remainder=5, out_valid 1 cycle after accept.
- Overflow edges:
  - dividend=0x0000_0001_0000_0000, divisor=1 -> overflow=1 via pre-check, latency 1.
  - dividend=-2147483648, divisor=-1 -> overflow=1 via SIGN.
  - dividend=2147483648, divisor=-1 -> quotient=0x80000000, overflow=0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> outputs and out_valid stable, in_ready=0; release -> IDLE next edge, new operands accepted the following cycle.
- Reset mid-operation: assert rst at CALC count=10 -> next edge out_valid=0, in_ready=0 during rst, 1 after; the subsequent 100/7 gives 14 r 2. With SEQ_DIVIDER_EARLY_EXIT_EN, 3/7 -> quotient 0, remainder 3 in 1 cycle.
